fifo_pkt_reader: RTL and testbench

Read-side engine for the registered-output packet FIFO used throughout the datapath: one `din`/`dout` word is `{ctrl, data}`, and `dout` is valid the cycle after `rd_en`. The block drains that FIFO and hides its one-cycle read latency behind a 2-entry skid buffer. It presents a valid/ready word stream to the next datapath module, tracks packet framing and flags framing errors. It sits between the output of an input-queue FIFO and the downstream pipeline stage.

---
 rtl/fifo_pkt_reader_pkg.sv | 15 +
 rtl/pkt_skid_buf.sv | 59 +++++
 rtl/fifo_pkt_reader.sv | 140 ++++++++++++++
 tb/tb_fifo_pkt_reader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkt_reader_pkg.sv
// Shared types and constants for the packet FIFO read-side engine.
package fifo_pkt_reader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } pkt_state_e;

  // ctrl value that marks a plain data (payload) word
  localparam int unsigned CTRL_DATA_WORD = 0;

  localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/pkt_skid_buf.sv
// Two-entry in-order skid buffer that absorbs the FIFO's registered read latency.
module pkt_skid_buf
  import fifo_pkt_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 72
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic [1:0]       occ_o
);

  logic [WIDTH-1:0] mem_q [SKID_DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;

  // Pointer/occupancy update; push and pop together leave occ unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_i) wr_ptr_d = ~wr_ptr_q;
    if (pop_i)  rd_ptr_d = ~rd_ptr_q;
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_data_o = mem_q[rd_ptr_q];
  assign occ_o       = occ_q;

  a_no_full_capture: assert property (@(posedge clk) disable iff (reset)
    !(push_i && !pop_i && (occ_q == 2'd2)));
  a_no_empty_pop: assert property (@(posedge clk) disable iff (reset)
    !(pop_i && (occ_q == 2'd0)));

endmodule

// File: rtl/fifo_pkt_reader.sv
// Drains a registered-output packet FIFO into a valid/ready stream with framing checks.
// Optional statistics counters are built when FIFO_PKT_READER_STATS_EN is defined.
module fifo_pkt_reader
  import fifo_pkt_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CTRL_WIDTH+DATA_WIDTH-1:0] fifo_dout,
  input  logic                           fifo_empty,
  output logic                           fifo_rd_en,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [CTRL_WIDTH-1:0]          out_ctrl,
  output logic                           out_wr,
  input  logic                           out_rdy,
  output logic                           in_pkt,
  output logic                           pkt_done,
  output logic                           frame_err,
  output logic [CNT_WIDTH-1:0]           pkt_count,
  output logic [CNT_WIDTH-1:0]           word_count
);

  localparam int unsigned WORD_WIDTH = CTRL_WIDTH + DATA_WIDTH;

  logic                  inflight_q;
  logic [1:0]            occ;
  logic [WORD_WIDTH-1:0] head;
  logic                  pop;
  logic [2:0]            credit;
  logic                  is_data;
  logic                  eop;

  pkt_state_e state_q, state_d;
  logic       frame_err_q, frame_err_d;
  logic       pkt_done_q, pkt_done_d;

  // Read credit: words held plus the one in flight, minus what leaves now, must stay below 2.
  assign out_wr     = ~reset & (occ != 2'd0) & out_rdy;
  assign pop        = out_wr;
  assign credit     = 3'(occ) + 3'(inflight_q) - 3'(pop);
  assign fifo_rd_en = ~reset & ~fifo_empty & (credit < 3'd2);

  always_ff @(posedge clk) begin
    if (reset) inflight_q <= 1'b0;
    else       inflight_q <= fifo_rd_en;
  end

  pkt_skid_buf #(.WIDTH(WORD_WIDTH)) u_skid (
    .clk         (clk),
    .reset       (reset),
    .push_i      (inflight_q),
    .push_data_i (fifo_dout),
    .pop_i       (pop),
    .head_data_o (head),
    .occ_o       (occ)
  );

  assign {out_ctrl, out_data} = head;
  assign is_data = (out_ctrl == CTRL_WIDTH'(CTRL_DATA_WORD));

  // Framing FSM, advanced only by transferred words.
  always_comb begin
    state_d     = state_q;
    frame_err_d = frame_err_q;
    eop         = 1'b0;
    if (out_wr) begin
      case (state_q)
        IDLE: begin
          if (is_data) begin
            state_d     = PAYLOAD;
            frame_err_d = 1'b1;
          end else begin
            state_d = HDR;
          end
        end
        HDR:     if (is_data) state_d = PAYLOAD;
        PAYLOAD: begin
          if (!is_data) begin
            state_d = IDLE;
            eop     = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    pkt_done_d = eop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      frame_err_q <= 1'b0;
      pkt_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_err_q <= frame_err_d;
      pkt_done_q  <= pkt_done_d;
    end
  end

  assign in_pkt    = (state_q != IDLE);
  assign pkt_done  = pkt_done_q;
  assign frame_err = frame_err_q;

`ifdef FIFO_PKT_READER_STATS_EN
  logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;

  // Saturating statistics counters.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    word_cnt_d = word_cnt_q;
    if (out_wr && (word_cnt_q != '1)) word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
    if (eop && (pkt_cnt_q != '1))     pkt_cnt_d  = pkt_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign pkt_count  = pkt_cnt_q;
  assign word_count = word_cnt_q;
`else
  assign pkt_count  = '0;
  assign word_count = '0;
`endif

  a_no_empty_read: assert property (@(posedge clk) disable iff (reset)
    fifo_rd_en |-> !fifo_empty);

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed/table-driven bench for fifo_pkt_reader with a registered-output FIFO model.
module tb_fifo_pkt_reader;

  localparam int unsigned DW = 64;
  localparam int unsigned CW = 8;
  localparam int unsigned NW = 4;
  localparam int unsigned WW = CW + DW;

  logic          clk = 1'b0;
  logic          reset;
  logic [WW-1:0] fifo_dout = '0;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          out_wr;
  logic          out_rdy;
  logic          in_pkt;
  logic          pkt_done;
  logic          frame_err;
  logic [NW-1:0] pkt_count;
  logic [NW-1:0] word_count;

  always #5 clk = ~clk;

  fifo_pkt_reader #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .out_data   (out_data),
    .out_ctrl   (out_ctrl),
    .out_wr     (out_wr),
    .out_rdy    (out_rdy),
    .in_pkt     (in_pkt),
    .pkt_done   (pkt_done),
    .frame_err  (frame_err),
    .pkt_count  (pkt_count),
    .word_count (word_count)
  );

  // FIFO model: registered dout, flushed by the shared reset.
  logic [WW-1:0] mem [4096];
  int wr_idx = 0;
  int rd_idx = 0;
  assign fifo_empty = (rd_idx == wr_idx);

  always @(posedge clk) begin
    if (reset) begin
      rd_idx    <= wr_idx;
      fifo_dout <= '0;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= mem[rd_idx];
      rd_idx    <= rd_idx + 1;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int exp_cnt(input int n);
`ifdef FIFO_PKT_READER_STATS_EN
    return (n > 15) ? 15 : n;
`else
    return 0;
`endif
  endfunction

  logic          s_rd, s_wr, s_done;
  logic [WW-1:0] obuf [4096];
  int            on = 0;
  int            done_cnt = 0;
  int            empty_reads = 0;

  // One cycle: drive at posedge+1, sample at negedge, return at next posedge+1.
  task automatic step(input logic rdy);
    out_rdy = rdy;
    @(negedge clk);
    s_rd   = fifo_rd_en;
    s_wr   = out_wr;
    s_done = pkt_done;
    if (out_wr) begin
      obuf[on] = {out_ctrl, out_data};
      on++;
    end
    if (fifo_rd_en && fifo_empty) empty_reads++;
    if (pkt_done) done_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WW-1:0] w);
    mem[wr_idx] = w;
    wr_idx++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0);
    step(1'b0);
    reset = 1'b0;
    on = 0;
    done_cnt = 0;
  endtask

  typedef struct packed {
    logic [15:0] rdy;
    logic [15:0] rd;
    logic [15:0] wr;
    logic [15:0] done;
  } vec_t;

  vec_t          vt [2];
  logic [WW-1:0] pkt [4];
  logic [WW-1:0] pkt2 [3];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0]   a_rd, a_wr, a_done;
    logic [63:0]   rd64;
    logic [7:0]    rc;
    int            base, total, mism, budget;

    pkt[0] = {8'hFF, 64'hA0};
    pkt[1] = {8'h00, 64'hD1};
    pkt[2] = {8'h00, 64'hD2};
    pkt[3] = {8'h04, 64'hD3};
    pkt2[0] = {8'h11, 64'hB0};
    pkt2[1] = {8'h00, 64'hB1};
    pkt2[2] = {8'h22, 64'hB2};
    // rdy mask, expected fifo_rd_en, out_wr and pkt_done cycle masks
    vt[0] = '{rdy: 16'hFFFF, rd: 16'h000F, wr: 16'h003C, done: 16'h0040};
    vt[1] = '{rdy: 16'hFF87, rd: 16'h0087, wr: 16'h0384, done: 16'h0400};

    reset   = 1'b1;
    out_rdy = 1'b0;
    do_reset();

    step(1'b1);
    check("reset_rd_en", 96'(s_rd), 96'(0));
    check("reset_out_wr", 96'(s_wr), 96'(0));
    check("reset_pkt_done", 96'(s_done), 96'(0));
    check("reset_in_pkt", 96'(in_pkt), 96'(0));
    check("reset_frame_err", 96'(frame_err), 96'(0));
    check("reset_pkt_count", 96'(pkt_count), 96'(0));
    check("reset_word_count", 96'(word_count), 96'(0));

    for (int v = 0; v < 2; v++) begin
      do_reset();
      for (int i = 0; i < 4; i++) push_word(pkt[i]);
      a_rd = '0; a_wr = '0; a_done = '0;
      for (int c = 0; c < 16; c++) begin
        step(vt[v].rdy[c]);
        a_rd[c]   = s_rd;
        a_wr[c]   = s_wr;
        a_done[c] = s_done;
      end
      check($sformatf("vec%0d_rd_mask", v), 96'(a_rd), 96'(vt[v].rd));
      check($sformatf("vec%0d_wr_mask", v), 96'(a_wr), 96'(vt[v].wr));
      check($sformatf("vec%0d_done_mask", v), 96'(a_done), 96'(vt[v].done));
      check($sformatf("vec%0d_nwords", v), 96'(on), 96'(4));
      for (int i = 0; i < 4; i++)
        check($sformatf("vec%0d_word%0d", v, i), 96'(obuf[i]), 96'(pkt[i]));
      check($sformatf("vec%0d_pkt_count", v), 96'(pkt_count), 96'(exp_cnt(1)));
      check($sformatf("vec%0d_word_count", v), 96'(word_count), 96'(exp_cnt(4)));
      check($sformatf("vec%0d_frame_err", v), 96'(frame_err), 96'(0));
    end

    // Framing error: payload word with the FSM idle.
    do_reset();
    push_word({8'h00, 64'h55});
    for (int c = 0; c < 3; c++) step(1'b1);
    check("ferr_word_out", 96'(s_wr), 96'(1));
    step(1'b1);
    check("ferr_set", 96'(frame_err), 96'(1));
    check("ferr_in_pkt", 96'(in_pkt), 96'(1));
    push_word({8'h04, 64'h66});
    for (int c = 0; c < 6; c++) step(1'b1);
    check("ferr_payload_eop_done", 96'(done_cnt), 96'(1));
    check("ferr_back_idle", 96'(in_pkt), 96'(0));
    check("ferr_sticky", 96'(frame_err), 96'(1));
    check("ferr_word_count", 96'(word_count), 96'(exp_cnt(2)));

    // Reset after the second word transfers.
    do_reset();
    for (int i = 0; i < 4; i++) push_word(pkt[i]);
    for (int c = 0; c < 4; c++) step(1'b1);
    check("rst_two_words", 96'(on), 96'(2));
    reset = 1'b1;
    step(1'b1);
    check("rst_out_wr_during", 96'(s_wr), 96'(0));
    reset = 1'b0;
    step(1'b1);
    check("rst_out_wr_after", 96'(s_wr), 96'(0));
    check("rst_rd_en_after", 96'(s_rd), 96'(0));
    check("rst_in_pkt", 96'(in_pkt), 96'(0));
    check("rst_pkt_count", 96'(pkt_count), 96'(0));
    check("rst_word_count", 96'(word_count), 96'(0));
    on = 0;
    done_cnt = 0;
    for (int i = 0; i < 3; i++) push_word(pkt2[i]);
    for (int c = 0; c < 10; c++) step(1'b1);
    check("rst_next_nwords", 96'(on), 96'(3));
    for (int i = 0; i < 3; i++)
      check($sformatf("rst_next_word%0d", i), 96'(obuf[i]), 96'(pkt2[i]));
    check("rst_next_done", 96'(done_cnt), 96'(1));
    check("rst_next_pkt_count", 96'(pkt_count), 96'(exp_cnt(1)));
    check("rst_next_word_count", 96'(word_count), 96'(exp_cnt(3)));

    // 100 random packets with random out_rdy.
    do_reset();
    base = wr_idx;
    for (int p = 0; p < 100; p++) begin
      int nh, np;
      nh = $urandom_range(2, 1);
      np = $urandom_range(3, 1);
      for (int i = 0; i < nh; i++) begin
        rc = 8'($urandom_range(255, 1));
        rd64 = {$urandom(), $urandom()};
        push_word({rc, rd64});
      end
      for (int i = 0; i < np; i++) begin
        rd64 = {$urandom(), $urandom()};
        push_word({8'h00, rd64});
      end
      rc = 8'($urandom_range(255, 1));
      rd64 = {$urandom(), $urandom()};
      push_word({rc, rd64});
    end
    total = wr_idx - base;
    budget = 0;
    while (on < total && budget < 20000) begin
      step(1'($urandom_range(1, 0)));
      budget++;
    end
    step(1'b1);
    step(1'b1);
    check("rand_nwords", 96'(on), 96'(total));
    mism = 0;
    for (int i = 0; i < on && i < total; i++)
      if (obuf[i] !== mem[base + i]) mism++;
    check("rand_stream_mismatches", 96'(mism), 96'(0));
    check("rand_pkt_done_count", 96'(done_cnt), 96'(100));
    check("rand_frame_err", 96'(frame_err), 96'(0));
    check("rand_empty_reads", 96'(empty_reads), 96'(0));
    check("rand_word_count", 96'(word_count), 96'(exp_cnt(total)));
    check("rand_pkt_count", 96'(pkt_count), 96'(exp_cnt(100)));

    // Saturation: 20 minimal packets (header, payload, EOP).
    do_reset();
    for (int p = 0; p < 20; p++) begin
      push_word({8'h01, 64'(p)});
      push_word({8'h00, 64'(p + 100)});
      push_word({8'h01, 64'(p + 200)});
    end
    budget = 0;
    while (on < 60 && budget < 500) begin
      step(1'b1);
      budget++;
    end
    step(1'b1);
    step(1'b1);
    check("sat_nwords", 96'(on), 96'(60));
    check("sat_done_count", 96'(done_cnt), 96'(20));
    check("sat_pkt_count", 96'(pkt_count), 96'(exp_cnt(20)));
    check("sat_word_count", 96'(word_count), 96'(exp_cnt(60)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
